// File: rtl/time_unit_cnt.sv
// Chainable modulo time-unit counter (seconds/minutes/hours) with a registered
// wrap carry and an edit mode driven by edge-detected, optionally auto-repeating buttons.
module time_unit_cnt #(
    parameter int MODULO     = 60,
    parameter int ST_VAL     = 0,
    parameter int W          = $clog2(MODULO),
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         user_time_val_i,
    input  logic         user_up_i,
    input  logic         user_dn_i,
    input  logic         tick_i,
    output logic [W-1:0] val_o,
    output logic         carry_o
);

    localparam logic [W-1:0] MAX_VAL   = W'(MODULO - 1);
    localparam logic [W-1:0] START_VAL = W'(ST_VAL);

    localparam bit REPEAT_EN = (REPEAT_DLY > 0);
    localparam int HW        = REPEAT_EN ? $clog2(REPEAT_DLY + 1) : 1;
    localparam int PW        = $clog2(REPEAT_PER + 1);

    localparam logic [HW-1:0] DLY_VAL = HW'(REPEAT_EN ? REPEAT_DLY : 0);
    localparam logic [HW-1:0] DLY_M1  = HW'(REPEAT_EN ? REPEAT_DLY - 1 : 0);
    localparam logic [PW-1:0] PER_M1  = PW'(REPEAT_PER - 1);

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]    btn_in;
    logic [1:0]    btn_q;
    logic [1:0]    btn_d;
    logic [1:0]    btn_edge;
    logic [1:0]    btn_held;
    logic [1:0]    btn_rep;
    logic [1:0]    btn_stb;
    logic [HW-1:0] hold_cnt [2];
    logic [PW-1:0] per_cnt  [2];
    logic [W-1:0]  user_val;
    logic          up_stb;
    logic          dn_stb;

    assign btn_in = {user_dn_i, user_up_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q <= '0;
            btn_d <= '0;
        end else begin
            btn_q <= btn_in;
            btn_d <= btn_q;
        end
    end

    assign btn_edge = btn_q & ~btn_d;
    assign btn_held = btn_q & btn_d;

    // hold_cnt saturates at REPEAT_DLY; per_cnt then paces the repeat steps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                hold_cnt[b] <= '0;
                per_cnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!btn_q[b]) begin
                    hold_cnt[b] <= '0;
                    per_cnt[b]  <= '0;
                end else if (btn_held[b]) begin
                    if (hold_cnt[b] != DLY_VAL) begin
                        hold_cnt[b] <= hold_cnt[b] + HW'(1);
                    end else if (per_cnt[b] == PER_M1) begin
                        per_cnt[b] <= '0;
                    end else begin
                        per_cnt[b] <= per_cnt[b] + PW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        btn_rep = '0;
        for (int b = 0; b < 2; b++) begin
            if (REPEAT_EN && btn_held[b]) begin
                if (hold_cnt[b] != DLY_VAL) begin
                    btn_rep[b] = (hold_cnt[b] == DLY_M1);
                end else begin
                    btn_rep[b] = (per_cnt[b] == PER_M1);
                end
            end
        end
    end

    assign btn_stb = btn_edge | btn_rep;
    assign up_stb  = btn_stb[0];
    assign dn_stb  = btn_stb[1];

    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
        return (v == MAX_VAL) ? '0 : v + W'(1);
    endfunction

    function automatic logic [W-1:0] wrap_dec(input logic [W-1:0] v);
        return (v == '0) ? MAX_VAL : v - W'(1);
    endfunction

    // user_val shadows val_o in run mode so edits start from the current time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_o    <= START_VAL;
            user_val <= '0;
            carry_o  <= 1'b0;
        end else if (user_time_val_i) begin
            val_o   <= user_val;
            carry_o <= 1'b0;
            case ({dn_stb, up_stb})
                2'b01:   user_val <= wrap_inc(user_val);
                2'b10:   user_val <= wrap_dec(user_val);
                default: user_val <= user_val;
            endcase
        end else begin
            user_val <= val_o;
            carry_o  <= tick_i & (val_o == MAX_VAL);
            if (tick_i) begin
                val_o <= wrap_inc(val_o);
            end
        end
    end

endmodule

// File: tb/tb_time_unit_cnt.sv
// Bench for time_unit_cnt: directed scenarios on seconds/minutes/hours instances
// plus a randomized run against a run-length based reference model.
module tb_time_unit_cnt;

    localparam int S_MOD = 60;
    localparam int S_ST  = 7;
    localparam int S_DLY = 10;
    localparam int S_PER = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic s_edit = 1'b0, s_up = 1'b0, s_dn = 1'b0, s_tick = 1'b0;
    logic m_edit = 1'b0, m_up = 1'b0, m_dn = 1'b0, m_tick = 1'b0;
    logic h_edit = 1'b0, h_up = 1'b0, h_dn = 1'b0;
    logic [5:0] s_val;
    logic [5:0] m_val;
    logic [4:0] h_val;
    logic s_carry, m_carry, h_carry;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    time_unit_cnt #(.MODULO(S_MOD), .ST_VAL(S_ST), .REPEAT_DLY(S_DLY), .REPEAT_PER(S_PER)) u_sec (
        .clk_i(clk), .rst_i(rst), .user_time_val_i(s_edit), .user_up_i(s_up),
        .user_dn_i(s_dn), .tick_i(s_tick), .val_o(s_val), .carry_o(s_carry)
    );

    time_unit_cnt #(.MODULO(60)) u_min (
        .clk_i(clk), .rst_i(rst), .user_time_val_i(m_edit), .user_up_i(m_up),
        .user_dn_i(m_dn), .tick_i(m_tick), .val_o(m_val), .carry_o(m_carry)
    );

    time_unit_cnt #(.MODULO(24)) u_hr (
        .clk_i(clk), .rst_i(rst), .user_time_val_i(h_edit), .user_up_i(h_up),
        .user_dn_i(h_dn), .tick_i(m_carry), .val_o(h_val), .carry_o(h_carry)
    );

    // Reference for u_sec: button strobes derived from how many consecutive
    // sampled-high cycles each button has accumulated.
    int m_val_r, m_user, up_len, dn_len;
    bit m_carry_r;

    function automatic bit strobe_at(input int len);
        if (len == 1) return 1'b1;
        if (len - 1 >= S_DLY && ((len - 1 - S_DLY) % S_PER) == 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin : ref_model
        bit us, ds;
        int nv, nu;
        if (rst) begin
            m_val_r   = S_ST;
            m_user    = 0;
            m_carry_r = 1'b0;
            up_len    = 0;
            dn_len    = 0;
        end else begin
            us = strobe_at(up_len);
            ds = strobe_at(dn_len);
            if (s_edit) begin
                nu = m_user;
                if (us && !ds) nu = (m_user + 1) % S_MOD;
                else if (ds && !us) nu = (m_user + S_MOD - 1) % S_MOD;
                m_val_r   = m_user;
                m_user    = nu;
                m_carry_r = 1'b0;
            end else begin
                nv        = s_tick ? (m_val_r + 1) % S_MOD : m_val_r;
                m_carry_r = s_tick && (m_val_r == S_MOD - 1);
                m_user    = m_val_r;
                m_val_r   = nv;
            end
            up_len = s_up ? (up_len < 100000 ? up_len + 1 : up_len) : 0;
            dn_len = s_dn ? (dn_len < 100000 ? dn_len + 1 : dn_len) : 0;
        end
    end

    task automatic test_reset();
        n_checks++; if (s_val !== 6'd7) $display("FAIL reset_sec_val: got %0d want 7", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b0) $display("FAIL reset_sec_carry: got %0b want 0", s_carry); else n_pass++;
        n_checks++; if (h_val !== 5'd0) $display("FAIL reset_hr_val: got %0d want 0", h_val); else n_pass++;
        s_tick = 1'b1;
        repeat (3) @(negedge clk);
        s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd10) $display("FAIL reset_pre_ticks: got %0d want 10", s_val); else n_pass++;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (s_val !== 6'd7) $display("FAIL reset_async_val: got %0d want 7", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b0) $display("FAIL reset_async_carry: got %0b want 0", s_carry); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (s_val !== 6'd7) $display("FAIL reset_release_val: got %0d want 7", s_val); else n_pass++;
    endtask

    task automatic test_run_wrap();
        bit carry_seen = 1'b0;
        s_tick = 1'b1;
        repeat (51) begin
            @(negedge clk);
            if (s_carry) carry_seen = 1'b1;
        end
        s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd58) $display("FAIL wrap_reach58: got %0d want 58", s_val); else n_pass++;
        n_checks++; if (carry_seen !== 1'b0) $display("FAIL wrap_early_carry: got %0b want 0", carry_seen); else n_pass++;
        s_tick = 1'b1; @(negedge clk); s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd59) $display("FAIL wrap_val59: got %0d want 59", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b0) $display("FAIL wrap_carry59: got %0b want 0", s_carry); else n_pass++;
        s_tick = 1'b1; @(negedge clk); s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd0) $display("FAIL wrap_val0: got %0d want 0", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b1) $display("FAIL wrap_carry_pulse: got %0b want 1", s_carry); else n_pass++;
        @(negedge clk);
        n_checks++; if (s_carry !== 1'b0) $display("FAIL wrap_carry_clear: got %0b want 0", s_carry); else n_pass++;
    endtask

    task automatic test_auto_repeat();
        s_edit = 1'b1;
        repeat (2) @(negedge clk);
        s_up = 1'b1;
        repeat (13) @(negedge clk);
        n_checks++; if (s_val !== 6'd2) $display("FAIL repeat_first: got %0d want 2", s_val); else n_pass++;
        repeat (17) @(negedge clk);
        n_checks++; if (s_val !== 6'd6) $display("FAIL repeat_held30: got %0d want 6", s_val); else n_pass++;
        s_up = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (s_val !== 6'd6) $display("FAIL repeat_release: got %0d want 6", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b0) $display("FAIL repeat_carry: got %0b want 0", s_carry); else n_pass++;
    endtask

    task automatic test_conflict_mode();
        s_up = 1'b1; s_dn = 1'b1;
        repeat (2) @(negedge clk);
        s_up = 1'b0; s_dn = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (s_val !== 6'd6) $display("FAIL conflict_val: got %0d want 6", s_val); else n_pass++;
        s_tick = 1'b1; @(negedge clk); s_tick = 1'b0;
        @(negedge clk);
        n_checks++; if (s_val !== 6'd6) $display("FAIL edit_tick_ignored: got %0d want 6", s_val); else n_pass++;
        repeat (36) begin
            s_up = 1'b1; @(negedge clk);
            s_up = 1'b0; @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_checks++; if (s_val !== 6'd42) $display("FAIL edit_to42: got %0d want 42", s_val); else n_pass++;
        s_edit = 1'b0; s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd43) $display("FAIL exit_tick: got %0d want 43", s_val); else n_pass++;
        n_checks++; if (s_carry !== 1'b0) $display("FAIL exit_carry: got %0b want 0", s_carry); else n_pass++;
        repeat (2) @(negedge clk);
        s_edit = 1'b1; s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
        n_checks++; if (s_val !== 6'd43) $display("FAIL enter_tick_drop: got %0d want 43", s_val); else n_pass++;
        @(negedge clk);
        n_checks++; if (s_val !== 6'd43) $display("FAIL enter_hold: got %0d want 43", s_val); else n_pass++;
        s_edit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_edit_wrap();
        h_edit = 1'b1;
        repeat (2) @(negedge clk);
        h_dn = 1'b1;
        @(negedge clk);
        h_dn = 1'b0;
        @(negedge clk);
        n_checks++; if (h_val !== 5'd0) $display("FAIL edit_dn_latency: got %0d want 0", h_val); else n_pass++;
        @(negedge clk);
        n_checks++; if (h_val !== 5'd23) $display("FAIL edit_dn_wrap: got %0d want 23", h_val); else n_pass++;
        n_checks++; if (h_carry !== 1'b0) $display("FAIL edit_dn_carry: got %0b want 0", h_carry); else n_pass++;
        h_up = 1'b1; @(negedge clk); h_up = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (h_val !== 5'd0) $display("FAIL edit_up_wrap: got %0d want 0", h_val); else n_pass++;
        n_checks++; if (h_carry !== 1'b0) $display("FAIL edit_up_carry: got %0b want 0", h_carry); else n_pass++;
        h_up = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++; if (h_val !== 5'd1) $display("FAIL edit_hold_single: got %0d want 1", h_val); else n_pass++;
        h_up = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (h_val !== 5'd1) $display("FAIL edit_hold_release: got %0d want 1", h_val); else n_pass++;
        repeat (2) begin
            h_dn = 1'b1; @(negedge clk);
            h_dn = 1'b0; @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++; if (h_val !== 5'd23) $display("FAIL edit_set23: got %0d want 23", h_val); else n_pass++;
        h_edit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cascade();
        m_edit = 1'b1;
        repeat (2) @(negedge clk);
        m_dn = 1'b1; @(negedge clk); m_dn = 1'b0;
        repeat (4) @(negedge clk);
        m_edit = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (m_val !== 6'd59) $display("FAIL cascade_min59: got %0d want 59", m_val); else n_pass++;
        n_checks++; if (h_val !== 5'd23) $display("FAIL cascade_hr23: got %0d want 23", h_val); else n_pass++;
        m_tick = 1'b1; @(negedge clk); m_tick = 1'b0;
        n_checks++; if (m_val !== 6'd0) $display("FAIL cascade_min0: got %0d want 0", m_val); else n_pass++;
        n_checks++; if (m_carry !== 1'b1) $display("FAIL cascade_min_carry: got %0b want 1", m_carry); else n_pass++;
        n_checks++; if (h_val !== 5'd23) $display("FAIL cascade_hr_lag: got %0d want 23", h_val); else n_pass++;
        @(negedge clk);
        n_checks++; if (h_val !== 5'd0) $display("FAIL cascade_hr0: got %0d want 0", h_val); else n_pass++;
        n_checks++; if (h_carry !== 1'b1) $display("FAIL cascade_hr_carry: got %0b want 1", h_carry); else n_pass++;
        n_checks++; if (m_carry !== 1'b0) $display("FAIL cascade_min_carry_clr: got %0b want 0", m_carry); else n_pass++;
        @(negedge clk);
        n_checks++; if (h_carry !== 1'b0) $display("FAIL cascade_hr_carry_clr: got %0b want 0", h_carry); else n_pass++;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (int'(s_val) !== m_val_r) $display("FAIL random_val cyc %0d: got %0d want %0d", cyc, s_val, m_val_r);
            else n_pass++;
            n_checks++;
            if (s_carry !== m_carry_r) $display("FAIL random_carry cyc %0d: got %0b want %0b", cyc, s_carry, m_carry_r);
            else n_pass++;
            if ($urandom_range(0, 24) == 0) s_edit = ~s_edit;
            if ($urandom_range(0, 11) == 0) s_up = ~s_up;
            if ($urandom_range(0, 13) == 0) s_dn = ~s_dn;
            s_tick = ($urandom_range(0, 2) == 0);
        end
        s_edit = 1'b0; s_up = 1'b0; s_dn = 1'b0; s_tick = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_run_wrap();
        test_auto_repeat();
        test_conflict_mode();
        test_edit_wrap();
        test_cascade();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
